// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (one command byte per request).
// The host inhibits the bus, issues a request-to-send and then presents one
// bit per device falling edge: 8 data bits LSB first, odd parity and stop.
// The device ACK is sampled on the 11th fall.
// PS2_CLK/PS2_DATA are driven open-drain through kclk_oe/kdata_oe.
// Optional build macro: PS2_TX_RETRY_EN. When it is defined, a failed frame is
// retried twice with the same byte, and err pulses only after the third failure.
module ps2_host_tx #(
   parameter int unsigned CLK_FREQ_HZ      = 50000000,
   parameter int unsigned INHIBIT_US       = 100,
   parameter int unsigned START_TIMEOUT_US = 15000,
   parameter int unsigned EDGE_TIMEOUT_US  = 2000,
   parameter int unsigned FILTER_CYCLES    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       kclk_in,
   input  logic       kdata_in,
   output logic       kclk_oe,
   output logic       kdata_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Cycle counts derived from the clock frequency (64-bit to avoid overflow).
   localparam longint unsigned INHIBIT_CYC = (64'(INHIBIT_US) * 64'(CLK_FREQ_HZ)) / 64'd1000000;
   localparam longint unsigned START_CYC   = (64'(START_TIMEOUT_US) * 64'(CLK_FREQ_HZ)) / 64'd1000000;
   localparam longint unsigned EDGE_CYC    = (64'(EDGE_TIMEOUT_US) * 64'(CLK_FREQ_HZ)) / 64'd1000000;
   localparam longint unsigned MAX_AB      = (START_CYC > EDGE_CYC) ? START_CYC : EDGE_CYC;
   localparam longint unsigned TMR_MAX     = (MAX_AB > INHIBIT_CYC) ? MAX_AB : INHIBIT_CYC;
   localparam int TMR_W = $clog2(TMR_MAX + 64'd1);
   // The timer is loaded with N-1, so an interval of N cycles ends when it reads zero.
   localparam logic [TMR_W-1:0] INHIBIT_LD = TMR_W'(INHIBIT_CYC - 64'd1);
   localparam logic [TMR_W-1:0] START_LD   = TMR_W'(START_CYC - 64'd1);
   localparam logic [TMR_W-1:0] EDGE_LD    = TMR_W'(EDGE_CYC - 64'd1);
   localparam int FC_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5,
      ST_DONE      = 3'd6,
      ST_ERR       = 3'd7
   } state_t;

   // Odd parity bit for one data byte.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   state_t            state_r, state_nxt_s;
   logic [TMR_W-1:0]  timer_r, timer_nxt_s;
   logic [3:0]        bitcnt_r, bitcnt_nxt_s;
   logic [10:0]       shreg_r, shreg_nxt_s;
   logic              timer_zero_s;
   logic              err_final_s;
   logic              kclk_meta_r, kclk_sync_r, kdata_meta_r, kdata_sync_r;
   logic              kclk_filt_r, kclk_fall_r;
   logic [FC_W-1:0]   filt_cnt_r;
   logic              tx_ready_r, kclk_oe_r, kdata_oe_r, busy_r, done_r, err_r;
   logic              tx_ready_nxt_s, kclk_oe_nxt_s, kdata_oe_nxt_s, busy_nxt_s, done_nxt_s, err_nxt_s;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]        retry_r, retry_nxt_s;
`endif

   assign timer_zero_s = (timer_r == {TMR_W{1'b0}});
`ifdef PS2_TX_RETRY_EN
   assign err_final_s = (retry_r == 2'd2);
`else
   assign err_final_s = 1'b1;
`endif

   // Two-flop synchronisers for both pads (bus idles high).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kclk_meta_r  <= 1'b1;
         kclk_sync_r  <= 1'b1;
         kdata_meta_r <= 1'b1;
         kdata_sync_r <= 1'b1;
      end else begin
         kclk_meta_r  <= kclk_in;
         kclk_sync_r  <= kclk_meta_r;
         kdata_meta_r <= kdata_in;
         kdata_sync_r <= kdata_meta_r;
      end
   end

   // kclk glitch filter: accept a level only after FILTER_CYCLES equal samples, strobe on 1->0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kclk_filt_r <= 1'b1;
         filt_cnt_r  <= {FC_W{1'b0}};
         kclk_fall_r <= 1'b0;
      end else if (kclk_sync_r != kclk_filt_r) begin
         if (filt_cnt_r == FC_LAST) begin
            kclk_filt_r <= kclk_sync_r;
            filt_cnt_r  <= {FC_W{1'b0}};
            kclk_fall_r <= ~kclk_sync_r;
         end else begin
            filt_cnt_r  <= filt_cnt_r + FC_W'(1'b1);
            kclk_fall_r <= 1'b0;
         end
      end else begin
         filt_cnt_r  <= {FC_W{1'b0}};
         kclk_fall_r <= 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Frame datapath registers: timer, bit index, frame, retry count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_r  <= {TMR_W{1'b0}};
         bitcnt_r <= 4'd0;
         shreg_r  <= 11'd0;
`ifdef PS2_TX_RETRY_EN
         retry_r  <= 2'd0;
`endif
      end else begin
         timer_r  <= timer_nxt_s;
         bitcnt_r <= bitcnt_nxt_s;
         shreg_r  <= shreg_nxt_s;
`ifdef PS2_TX_RETRY_EN
         retry_r  <= retry_nxt_s;
`endif
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_nxt_s  = state_r;
      timer_nxt_s  = timer_zero_s ? timer_r : (timer_r - TMR_W'(1'b1));
      bitcnt_nxt_s = bitcnt_r;
      shreg_nxt_s  = shreg_r;
`ifdef PS2_TX_RETRY_EN
      retry_nxt_s  = retry_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (tx_valid) begin
               state_nxt_s  = ST_INHIBIT;
               timer_nxt_s  = INHIBIT_LD;
               shreg_nxt_s  = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
               bitcnt_nxt_s = 4'd0;
`ifdef PS2_TX_RETRY_EN
               retry_nxt_s  = 2'd0;
`endif
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_INHIBIT: begin
            if (timer_zero_s) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_INHIBIT;
            end
         end
         ST_REQ: begin
            state_nxt_s  = ST_SEND;
            timer_nxt_s  = START_LD;
            bitcnt_nxt_s = 4'd0;
         end
         ST_SEND: begin
            if (kclk_fall_r) begin
               bitcnt_nxt_s = bitcnt_r + 4'd1;
               timer_nxt_s  = EDGE_LD;
               if (bitcnt_r == 4'd9) begin
                  state_nxt_s = ST_ACK;
               end else begin
                  state_nxt_s = ST_SEND;
               end
            end else if (timer_zero_s) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         ST_ACK: begin
            if (kclk_fall_r) begin
               timer_nxt_s = EDGE_LD;
               if (!kdata_sync_r) begin
                  state_nxt_s = ST_WAIT_IDLE;
               end else begin
                  state_nxt_s = ST_ERR;
               end
            end else if (timer_zero_s) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_ACK;
            end
         end
         ST_WAIT_IDLE: begin
            if (kclk_filt_r && kdata_sync_r) begin
               state_nxt_s = ST_DONE;
            end else if (timer_zero_s) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_WAIT_IDLE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
`ifdef PS2_TX_RETRY_EN
            retry_nxt_s = 2'd0;
`endif
         end
         ST_ERR: begin
`ifdef PS2_TX_RETRY_EN
            if (!err_final_s) begin
               state_nxt_s  = ST_INHIBIT;
               timer_nxt_s  = INHIBIT_LD;
               bitcnt_nxt_s = 4'd0;
               retry_nxt_s  = retry_r + 2'd1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
`else
            state_nxt_s = ST_IDLE;
`endif
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state, so registered outputs align with the state.
   always_comb begin
      tx_ready_nxt_s = 1'b0;
      kclk_oe_nxt_s  = 1'b0;
      kdata_oe_nxt_s = 1'b0;
      done_nxt_s     = 1'b0;
      err_nxt_s      = 1'b0;
      busy_nxt_s     = (state_nxt_s != ST_IDLE);
      case (state_nxt_s)
         ST_IDLE:    tx_ready_nxt_s = 1'b1;
         ST_INHIBIT: kclk_oe_nxt_s  = 1'b1;
         ST_REQ: begin
            kclk_oe_nxt_s  = 1'b1;
            kdata_oe_nxt_s = 1'b1;
         end
         ST_SEND:    kdata_oe_nxt_s = ~shreg_nxt_s[bitcnt_nxt_s];
         ST_DONE:    done_nxt_s     = 1'b1;
         ST_ERR:     err_nxt_s      = err_final_s;
         default:    tx_ready_nxt_s = 1'b0;
      endcase
   end

   // Output registers; reset releases both lines immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_ready_r <= 1'b1;
         kclk_oe_r  <= 1'b0;
         kdata_oe_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         tx_ready_r <= tx_ready_nxt_s;
         kclk_oe_r  <= kclk_oe_nxt_s;
         kdata_oe_r <= kdata_oe_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         err_r      <= err_nxt_s;
      end
   end

   assign tx_ready = tx_ready_r;
   assign kclk_oe  = kclk_oe_r;
   assign kdata_oe = kdata_oe_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;

endmodule
